// File: rtl/pz_dac_spi_mc.sv
// -----------------------------------------------------------------------------
// pz_dac_spi_mc : multi-channel SPI DAC master
//
// Sweeps the channels enabled in da_ch_mask, lowest index first. Each channel
// gets one frame {channel index, value} shifted MSB first on da_spi_mosi while
// da_nsync is low. MISO is captured on every falling SCLK edge and the last
// DATA_W bits are presented as a readback word when nsync rises. After the
// sweep, da_done pulses and an optional gap of da_fre cycles is inserted.
//
// Parameters : DATA_W  data bits per frame
//              ADDR_W  channel address bits prepended to each frame
//              NUM_CH  number of channels (NUM_CH <= 2**ADDR_W)
//              CLK_DIV SCLK half period H in da_spi_clk cycles (>= 1)
//
// Ports      : da_spi_clk / rst_n          clock, async active-low reset
//              da_en, da_ch_mask,          sweep request and sweep set-up,
//              da_value_i, da_fre          latched when a sweep starts
//              da_busy, da_done            sweep status
//              da_value_o, da_rb_ch,       readback word, its channel and
//              da_rb_valid                 its one-cycle strobe
//              da_nsync, da_sclk,          SPI master pins
//              da_spi_mosi, da_spi_miso
//              da_ldac_n                   DAC load strobe (DA_LDAC_EN only)
//
// Build option: define DA_LDAC_EN to add da_ldac_n. After the last frame it
//              pulses low for H cycles and da_done follows one cycle after it
//              returns high. An empty mask issues no LDAC pulse.
// -----------------------------------------------------------------------------
module pz_dac_spi_mc #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 2,
   parameter int NUM_CH  = 4,
   parameter int CLK_DIV = 4
) (
   input  logic                     da_spi_clk,
   input  logic                     rst_n,
   input  logic                     da_en,
   input  logic [NUM_CH-1:0]        da_ch_mask,
   input  logic [NUM_CH*DATA_W-1:0] da_value_i,
   input  logic [31:0]              da_fre,
   output logic                     da_busy,
   output logic                     da_done,
   output logic [DATA_W-1:0]        da_value_o,
   output logic [ADDR_W-1:0]        da_rb_ch,
   output logic                     da_rb_valid,
   output logic                     da_nsync,
   output logic                     da_sclk,
   output logic                     da_spi_mosi,
`ifdef DA_LDAC_EN
   output logic                     da_ldac_n,
`endif
   input  logic                     da_spi_miso
);

   localparam int FRAME_W = ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(2*CLK_DIV + 1);
   localparam int BIT_W   = $clog2(FRAME_W + 1);

   localparam logic [CNT_W-1:0] CNT_H_M1  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_H     = CNT_W'(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_2H_M1 = CNT_W'(2*CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_HOLD  = 3'd3,
      S_LDAC  = 3'd4,
      S_DONE  = 3'd5,
      S_GAP   = 3'd6
   } state_t;

   state_t                    state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [BIT_W-1:0]          bit_q;
   logic [31:0]               gap_q;
   logic [ADDR_W-1:0]         ch_q;
   logic [NUM_CH-1:0]         mask_q;
   logic [NUM_CH*DATA_W-1:0]  val_q;
   logic [31:0]               fre_q;
   logic [FRAME_W-1:0]        tx_q;
   logic [DATA_W-1:0]         rx_q;
   logic                      busy_q;
   logic                      done_q;
   logic [DATA_W-1:0]         value_q;
   logic [ADDR_W-1:0]         rb_ch_q;
   logic                      rb_valid_q;
   logic                      nsync_q;
   logic                      sclk_q;
`ifdef DA_LDAC_EN
   logic                      ldac_q;
`endif

   // {found, index} of the first channel in the sweep and of the next one
   logic [ADDR_W:0]           first_d;
   logic [ADDR_W:0]           next_d;

   // Lowest set bit of m at or above start; MSB of the result flags a hit.
   function automatic logic [ADDR_W:0] find_ch(input logic [NUM_CH-1:0] m,
                                               input int start);
      logic [ADDR_W:0] r;
      r = {1'b0, {ADDR_W{1'b0}}};
      // Walk downwards so the lowest qualifying channel is the last writer.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i] && (i >= start)) begin
            r = {1'b1, ADDR_W'(i)};
         end
      end
      return r;
   endfunction

   // Frame for one channel: address bits ahead of the data word.
   function automatic logic [FRAME_W-1:0] frame_of(input logic [ADDR_W-1:0] ch,
                                                   input logic [NUM_CH*DATA_W-1:0] vals);
      return {ch, vals[int'(ch)*DATA_W +: DATA_W]};
   endfunction

   // Channel selection for sweep start (from live inputs) and for advancing.
   always_comb begin
      first_d = find_ch(da_ch_mask, 0);
      next_d  = find_ch(mask_q, int'(ch_q) + 1);
   end

   // Sweep sequencer: all SPI pins and status outputs are registered here.
   always_ff @(posedge da_spi_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         bit_q      <= {BIT_W{1'b0}};
         gap_q      <= 32'd0;
         ch_q       <= {ADDR_W{1'b0}};
         mask_q     <= {NUM_CH{1'b0}};
         val_q      <= {(NUM_CH*DATA_W){1'b0}};
         fre_q      <= 32'd0;
         tx_q       <= {FRAME_W{1'b0}};
         rx_q       <= {DATA_W{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         value_q    <= {DATA_W{1'b0}};
         rb_ch_q    <= {ADDR_W{1'b0}};
         rb_valid_q <= 1'b0;
         nsync_q    <= 1'b1;
         sclk_q     <= 1'b0;
`ifdef DA_LDAC_EN
         ldac_q     <= 1'b1;
`endif
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         done_q     <= 1'b0;
         rb_valid_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (da_en) begin
                  mask_q <= da_ch_mask;
                  val_q  <= da_value_i;
                  fre_q  <= da_fre;
                  busy_q <= 1'b1;
                  cnt_q  <= {CNT_W{1'b0}};
                  if (first_d[ADDR_W]) begin
                     ch_q    <= first_d[ADDR_W-1:0];
                     tx_q    <= frame_of(first_d[ADDR_W-1:0], da_value_i);
                     nsync_q <= 1'b0;
                     state_q <= S_SETUP;
                  end else begin
                     // Empty mask: report an (empty) sweep without touching SPI.
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end else begin
                  busy_q <= 1'b0;
               end
            end

            S_SETUP: begin
               if (cnt_q == CNT_H_M1) begin
                  cnt_q   <= {CNT_W{1'b0}};
                  bit_q   <= {BIT_W{1'b0}};
                  sclk_q  <= 1'b1;
                  state_q <= S_SHIFT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            S_SHIFT: begin
               // MOSI advances one clk after each rising SCLK except the last.
               if ((cnt_q == {CNT_W{1'b0}}) && (bit_q != BIT_LAST)) begin
                  tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
               end else begin
                  tx_q <= tx_q;
               end
               // Falling SCLK: sample MISO. Only the last DATA_W samples matter,
               // the address-phase bits fall off the top of the register.
               if (cnt_q == CNT_H_M1) begin
                  sclk_q <= 1'b0;
                  rx_q   <= {rx_q[DATA_W-2:0], da_spi_miso};
               end else begin
                  rx_q <= rx_q;
               end
               if (cnt_q == CNT_2H_M1) begin
                  cnt_q <= {CNT_W{1'b0}};
                  if (bit_q == BIT_LAST) begin
                     state_q <= S_HOLD;
                  end else begin
                     sclk_q <= 1'b1;
                     bit_q  <= bit_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            S_HOLD: begin
               // First H cycles: nsync low; next H cycles: nsync high.
               if (cnt_q == CNT_H_M1) begin
                  nsync_q    <= 1'b1;
                  value_q    <= rx_q;
                  rb_ch_q    <= ch_q;
                  rb_valid_q <= 1'b1;
               end else begin
                  nsync_q <= nsync_q;
               end
               if (cnt_q == CNT_2H_M1) begin
                  cnt_q <= {CNT_W{1'b0}};
                  if (next_d[ADDR_W]) begin
                     ch_q    <= next_d[ADDR_W-1:0];
                     tx_q    <= frame_of(next_d[ADDR_W-1:0], val_q);
                     nsync_q <= 1'b0;
                     state_q <= S_SETUP;
                  end else begin
`ifdef DA_LDAC_EN
                     ldac_q  <= 1'b0;
                     state_q <= S_LDAC;
`else
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
`endif
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

`ifdef DA_LDAC_EN
            S_LDAC: begin
               // LDAC low for H cycles, done one cycle after it returns high.
               if (cnt_q == CNT_H_M1) begin
                  ldac_q <= 1'b1;
               end else begin
                  ldac_q <= ldac_q;
               end
               if (cnt_q == CNT_H) begin
                  cnt_q   <= {CNT_W{1'b0}};
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
`endif

            S_DONE: begin
               if (fre_q == 32'd0) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  gap_q   <= 32'd0;
                  state_q <= S_GAP;
               end
            end

            S_GAP: begin
               if (gap_q == (fre_q - 32'd1)) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  gap_q <= gap_q + 32'd1;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               nsync_q <= 1'b1;
               sclk_q  <= 1'b0;
               cnt_q   <= {CNT_W{1'b0}};
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign da_busy     = busy_q;
   assign da_done     = done_q;
   assign da_value_o  = value_q;
   assign da_rb_ch    = rb_ch_q;
   assign da_rb_valid = rb_valid_q;
   assign da_nsync    = nsync_q;
   assign da_sclk     = sclk_q;
   assign da_spi_mosi = tx_q[FRAME_W-1];
`ifdef DA_LDAC_EN
   assign da_ldac_n   = ldac_q;
`endif

endmodule

// File: tb/tb_pz_dac_spi_mc.sv
// Scoreboard bench for pz_dac_spi_mc with CLK_DIV=2 (H=2), 18-bit frames.
// Stimulus pushes expected frames, readbacks, done events and gap lengths;
// a negedge monitor reconstructs SPI frames and pops/compares.
module tb_pz_dac_spi_mc;
   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 2;
   localparam int NUM_CH  = 4;
   localparam int CLK_DIV = 2;
   localparam int FRAME_W = 18;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        da_en;
   logic [3:0]  da_ch_mask;
   logic [63:0] da_value_i;
   logic [31:0] da_fre;
   logic        da_busy, da_done, da_rb_valid, da_nsync, da_sclk, da_spi_mosi;
   logic [15:0] da_value_o;
   logic [1:0]  da_rb_ch;
   logic        da_spi_miso;
`ifdef DA_LDAC_EN
   logic        da_ldac_n;
`endif

   always #5 clk = ~clk;

   pz_dac_spi_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV)) dut (
      .da_spi_clk (clk),
      .rst_n      (rst_n),
      .da_en      (da_en),
      .da_ch_mask (da_ch_mask),
      .da_value_i (da_value_i),
      .da_fre     (da_fre),
      .da_busy    (da_busy),
      .da_done    (da_done),
      .da_value_o (da_value_o),
      .da_rb_ch   (da_rb_ch),
      .da_rb_valid(da_rb_valid),
      .da_nsync   (da_nsync),
      .da_sclk    (da_sclk),
      .da_spi_mosi(da_spi_mosi),
`ifdef DA_LDAC_EN
      .da_ldac_n  (da_ldac_n),
`endif
      .da_spi_miso(da_spi_miso)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  ch;
      logic [15:0] val;
   } rb_t;

   logic [17:0] exp_frame_q[$];
   rb_t         exp_rb_q[$];
   int          exp_done_q[$];
   int          exp_gap_q[$];

   // ---------------- MISO slave model ----------------
   logic [17:0] miso_pat = 18'h0;
   logic [17:0] msh;
   logic        d_pns = 1'b1, d_psclk = 1'b0;
   always @(negedge clk) begin
      if (!da_nsync && d_pns) begin
         msh = miso_pat;
         da_spi_miso = msh[17];
      end else if (!da_nsync && d_psclk && !da_sclk) begin
         msh = {msh[16:0], 1'b0};
         da_spi_miso = msh[17];
      end
      d_pns   = da_nsync;
      d_psclk = da_sclk;
   end

   // ---------------- monitor ----------------
   int          cyc = 0;
   logic        p_ns = 1'b1, p_sclk = 1'b0;
   bit          in_frame = 0, per_bad = 0, done_flag = 0, bpend = 0;
   int          nlow = 0, nbits = 0, hi_run = 100, last_rise = 0;
   int          done_cyc = 0, bcnt = 0, bfre = 0, gexp = 0;
   int          sclk_rises = 0, ns_falls = 0, stray_sclk = 0;
   logic [17:0] cap, fexp;
   rb_t         rexp;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         in_frame  = 0;
         bpend     = 0;
         done_flag = 0;
      end else begin
         if (da_sclk && !p_sclk) begin
            sclk_rises++;
            if (in_frame) begin
               if (nbits > 0 && (cyc - last_rise) != 2*2*CLK_DIV/2) per_bad = 1;
               last_rise = cyc;
               cap = {cap[16:0], da_spi_mosi};
               nbits++;
            end else begin
               stray_sclk++;
            end
         end
         if (!da_nsync && p_ns) begin
            ns_falls++;
            chk("nsync_high_min", 64'(hi_run >= 2), 64'd1);
            if (done_flag && exp_gap_q.size() > 0) begin
               gexp = exp_gap_q.pop_front();
               chk("done_to_nsync_gap", 64'(cyc - done_cyc), 64'(gexp));
            end
            done_flag = 0;
            in_frame  = 1;
            nlow = 0; nbits = 0; per_bad = 0; cap = 18'h0;
         end
         if (!da_nsync) nlow++;
         if (da_nsync) hi_run++;
         if (da_nsync && !p_ns) begin
            hi_run = 1;
            if (in_frame) begin
               chk("nsync_low_cycles", 64'(nlow), 64'd76);
               chk("frame_bits", 64'(nbits), 64'd18);
               chk("sclk_period", 64'(per_bad), 64'd0);
               chk("frame_expected", 64'(exp_frame_q.size() > 0), 64'd1);
               if (exp_frame_q.size() > 0) begin
                  fexp = exp_frame_q.pop_front();
                  chk("mosi_frame", 64'(cap), 64'(fexp));
               end
               in_frame = 0;
            end
            chk("rb_valid_at_nsync_rise", 64'(da_rb_valid), 64'd1);
         end
         if (da_rb_valid) begin
            chk("rb_expected", 64'(exp_rb_q.size() > 0), 64'd1);
            if (exp_rb_q.size() > 0) begin
               rexp = exp_rb_q.pop_front();
               chk("rb_ch", 64'(da_rb_ch), 64'(rexp.ch));
               chk("rb_value", 64'(da_value_o), 64'(rexp.val));
            end
         end
         if (da_done) begin
            chk("done_expected", 64'(exp_done_q.size() > 0), 64'd1);
            bfre = (exp_done_q.size() > 0) ? exp_done_q.pop_front() : 0;
            bpend = 1; bcnt = 0;
            done_flag = 1; done_cyc = cyc;
         end else if (bpend) begin
            bcnt++;
            if (!da_busy) begin
               chk("busy_drop_after_done", 64'(bcnt), 64'(bfre + 1));
               bpend = 0;
            end else if (bcnt > bfre + 5) begin
               chk("busy_drop_timeout", 64'(bcnt), 64'(bfre + 1));
               bpend = 0;
            end
         end
      end
      p_ns   = da_nsync;
      p_sclk = da_sclk;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(input int maxc);
      int k;
      k = 0;
      while (da_busy && k < maxc) begin
         tick(1);
         k++;
      end
      chk("wait_idle", 64'(da_busy), 64'd0);
   endtask

   task automatic sweep(input logic [3:0] m, input logic [63:0] v, input logic [31:0] f);
      wait_idle(2000);
      da_ch_mask = m;
      da_value_i = v;
      da_fre     = f;
      da_en      = 1'b1;
      tick(1);
      da_en      = 1'b0;
      da_ch_mask = 4'hF;
      da_value_i = 64'hDEAD_BEEF_0BAD_F00D;
      da_fre     = 32'd7;
   endtask

   int snap_ns, snap_sc, k;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. reset with toggling inputs
      rst_n = 1'b0; da_en = 1'b0; da_ch_mask = 4'h0; da_value_i = 64'h0;
      da_fre = 32'd0; da_spi_miso = 1'b0;
      for (int i = 0; i < 6; i++) begin
         da_en = ~da_en; da_ch_mask = 4'(i + 1); da_spi_miso = ~da_spi_miso;
         tick(1);
      end
      chk("rst_nsync", 64'(da_nsync), 64'd1);
      chk("rst_sclk", 64'(da_sclk), 64'd0);
      chk("rst_mosi", 64'(da_spi_mosi), 64'd0);
      chk("rst_busy", 64'(da_busy), 64'd0);
      chk("rst_done", 64'(da_done), 64'd0);
      chk("rst_value_o", 64'(da_value_o), 64'd0);
      da_en = 1'b0;
      rst_n = 1'b1;
      tick(10);
      chk("post_rst_busy", 64'(da_busy), 64'd0);
      chk("post_rst_nsync_falls", 64'(ns_falls), 64'd0);

      // 2. single frame on ch0
      miso_pat = 18'h1_5A5A;
      exp_frame_q.push_back({2'b00, 16'hA5C3});
      exp_rb_q.push_back('{ch: 2'd0, val: 16'h5A5A});
      exp_done_q.push_back(0);
      sweep(4'b0001, {48'h0, 16'hA5C3}, 32'd0);
      wait_idle(500);

      // 3. channels 1 and 3
      miso_pat = 18'h2_C3C3;
      exp_frame_q.push_back({2'b01, 16'h1234});
      exp_frame_q.push_back({2'b11, 16'hFFFF});
      exp_rb_q.push_back('{ch: 2'd1, val: 16'hC3C3});
      exp_rb_q.push_back('{ch: 2'd3, val: 16'hC3C3});
      exp_done_q.push_back(0);
      sweep(4'b1010, {16'hFFFF, 16'h5555, 16'h1234, 16'hAAAA}, 32'd0);
      wait_idle(500);

      // 4. readback pattern 3BEEF on ch2
      miso_pat = 18'h3_BEEF;
      exp_frame_q.push_back({2'b10, 16'h0F0F});
      exp_rb_q.push_back('{ch: 2'd2, val: 16'hBEEF});
      exp_done_q.push_back(0);
      sweep(4'b0100, {16'h1111, 16'h0F0F, 16'h2222, 16'h3333}, 32'd0);
      wait_idle(500);
      tick(2);
      chk("value_o_hold", 64'(da_value_o), 64'hBEEF);
      chk("rb_ch_hold", 64'(da_rb_ch), 64'd2);

      // 5a. da_en held high, gap of 10 cycles between two sweeps
      miso_pat = 18'h0_1357;
      repeat (2) begin
         exp_frame_q.push_back({2'b00, 16'h8001});
         exp_rb_q.push_back('{ch: 2'd0, val: 16'h1357});
         exp_done_q.push_back(10);
      end
      wait_idle(500);
      da_ch_mask = 4'b0001; da_value_i = {48'h0, 16'h8001}; da_fre = 32'd10;
      da_en = 1'b1;
      tick(3);
      exp_gap_q.push_back(12);
      k = 0;
      while (da_busy && k < 500) begin tick(1); k++; end
      chk("sweep1_end", 64'(da_busy), 64'd0);
      k = 0;
      while (!da_busy && k < 5) begin tick(1); k++; end
      chk("sweep2_start", 64'(da_busy), 64'd1);
      da_en = 1'b0;
      wait_idle(500);

      // 5b. empty mask: done only, no SPI activity
      snap_ns = ns_falls; snap_sc = sclk_rises;
      exp_done_q.push_back(0);
      sweep(4'b0000, 64'h1234_5678_9ABC_DEF0, 32'd0);
      tick(5);
      chk("mask0_nsync_falls", 64'(ns_falls - snap_ns), 64'd0);
      chk("mask0_sclk_rises", 64'(sclk_rises - snap_sc), 64'd0);

      // 6. reset in the middle of SHIFT (bit 7)
      miso_pat = 18'h0_0F0F;
      snap_sc = sclk_rises;
      sweep(4'b0001, {48'h0, 16'hA5C3}, 32'd0);
      k = 0;
      while ((sclk_rises - snap_sc) < 8 && k < 200) begin tick(1); k++; end
      chk("reach_bit7", 64'(sclk_rises - snap_sc), 64'd8);
      rst_n = 1'b0;
      #1;
      chk("midrst_nsync", 64'(da_nsync), 64'd1);
      chk("midrst_sclk", 64'(da_sclk), 64'd0);
      chk("midrst_mosi", 64'(da_spi_mosi), 64'd0);
      chk("midrst_busy", 64'(da_busy), 64'd0);
      chk("midrst_done", 64'(da_done), 64'd0);
      chk("midrst_value_o", 64'(da_value_o), 64'd0);
      chk("midrst_rb_ch", 64'(da_rb_ch), 64'd0);
      tick(3);
      rst_n = 1'b1;
      tick(3);
      exp_frame_q.push_back({2'b00, 16'hA5C3});
      exp_rb_q.push_back('{ch: 2'd0, val: 16'h0F0F});
      exp_done_q.push_back(0);
      sweep(4'b0001, {48'h0, 16'hA5C3}, 32'd0);
      wait_idle(500);
      tick(20);

      chk("frames_left", 64'(exp_frame_q.size()), 64'd0);
      chk("rb_left", 64'(exp_rb_q.size()), 64'd0);
      chk("done_left", 64'(exp_done_q.size()), 64'd0);
      chk("gap_left", 64'(exp_gap_q.size()), 64'd0);
      chk("stray_sclk", 64'(stray_sclk), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
